// File: rtl/apb_spi_regif.sv
// apb_spi_regif
// APB3 zero-wait-state register file sitting between the APB bus and the SPI
// shift engine. It holds the SPI control register and the interrupt enables,
// and buffers bytes in two FIFOs: TX bytes from the bus toward the engine,
// and RX bytes from the engine toward the bus. It also produces a registered
// level interrupt.
//
// Ports
//   PCLK, PRESETn        clock; reset is synchronous and active low
//   PSEL .. PSLVERR      APB3 slave port (PREADY is tied high)
//   interrupt            |(INT_STAT & INT_EN), registered
//   spi_en/cpol/cpha     CTRL[0]/[1]/[2]
//   spi_clk_div          CTRL[15:8]
//   spi_tx_*             TX FIFO head, valid/ready pop handshake
//   spi_rx_*             RX byte and its one-cycle push strobe
//   spi_busy             engine mid-frame, reported in STATUS[4]
//
// Register map (byte offsets)
//   0x00 CTRL, 0x04 STATUS, 0x08 TXDATA, 0x0C RXDATA, 0x10 INT_EN,
//   0x14 INT_STAT (W1C on rx_ovf)
module apb_spi_regif #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int APB_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [APB_DATA_WIDTH-1:0] PWDATA,
  output logic [APB_DATA_WIDTH-1:0] PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      interrupt,
  output logic                      spi_en,
  output logic                      spi_cpol,
  output logic                      spi_cpha,
  output logic [7:0]                spi_clk_div,
  output logic [7:0]                spi_tx_data,
  output logic                      spi_tx_valid,
  input  logic                      spi_tx_ready,
  input  logic [7:0]                spi_rx_data,
  input  logic                      spi_rx_valid,
  input  logic                      spi_busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Control and interrupt state
  logic            ctrl_en_q, ctrl_cpol_q, ctrl_cpha_q;
  logic [7:0]      clk_div_q;
  logic [2:0]      int_en_q;
  logic            rx_ovf_q, rx_ovf_d;
  logic            irq_q;

  // FIFO state
  logic [7:0]      tx_mem [FIFO_DEPTH];
  logic [7:0]      rx_mem [FIFO_DEPTH];
  logic [PW-1:0]   tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [PW-1:0]   rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

  // Decode
  logic            access, wr_acc, rd_acc, addr_ok;
  logic [2:0]      idx;
  logic            tx_full, tx_empty, rx_full, rx_empty;
  logic            flush, tx_push, tx_pop, rx_push, rx_pop, ovf_set, ovf_clr;
  logic [2:0]      int_stat;
  logic [31:0]     rdata;
  logic            unused_bits;

  // Gating with PRESETn keeps PRDATA/PSLVERR at 0 while reset is held.
  assign access  = PSEL & PENABLE & PRESETn;
  assign wr_acc  = access & PWRITE;
  assign rd_acc  = access & ~PWRITE;
  assign idx     = PADDR[4:2];
  assign addr_ok = (PADDR[APB_ADDR_WIDTH-1:5] == '0) && (idx <= 3'd5);

  assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

  // Full/empty are judged on the pre-edge counts, so a same-cycle pop never
  // makes room for a push into a full FIFO.
  assign flush   = wr_acc & addr_ok & (idx == 3'd0) & PWDATA[3];
  assign tx_push = wr_acc & addr_ok & (idx == 3'd2) & ~tx_full;
  assign tx_pop  = spi_tx_valid & spi_tx_ready;
  assign rx_push = spi_rx_valid & ~rx_full;
  assign rx_pop  = rd_acc & addr_ok & (idx == 3'd3) & ~rx_empty;
  assign ovf_set = spi_rx_valid & rx_full;
  assign ovf_clr = wr_acc & addr_ok & (idx == 3'd5) & PWDATA[2];

  assign int_stat = {rx_ovf_q, ~rx_empty, tx_empty};

  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    if (flush) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
      tx_cnt_d  = '0;
      rx_wptr_d = '0;
      rx_rptr_d = '0;
      rx_cnt_d  = '0;
    end else begin
      if (tx_push) tx_wptr_d = tx_wptr_q + PW'(1);
      if (tx_pop)  tx_rptr_d = tx_rptr_q + PW'(1);
      tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
      if (rx_push) rx_wptr_d = rx_wptr_q + PW'(1);
      if (rx_pop)  rx_rptr_d = rx_rptr_q + PW'(1);
      rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    end
    // A new overflow outranks a same-cycle clear.
    rx_ovf_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : rx_ovf_q);
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      ctrl_en_q   <= 1'b0;
      ctrl_cpol_q <= 1'b0;
      ctrl_cpha_q <= 1'b0;
      clk_div_q   <= '0;
      int_en_q    <= '0;
      rx_ovf_q    <= 1'b0;
      irq_q       <= 1'b0;
      tx_wptr_q   <= '0;
      tx_rptr_q   <= '0;
      tx_cnt_q    <= '0;
      rx_wptr_q   <= '0;
      rx_rptr_q   <= '0;
      rx_cnt_q    <= '0;
    end else begin
      if (wr_acc && addr_ok && idx == 3'd0) begin
        ctrl_en_q   <= PWDATA[0];
        ctrl_cpol_q <= PWDATA[1];
        ctrl_cpha_q <= PWDATA[2];
        clk_div_q   <= PWDATA[15:8];
      end
      if (wr_acc && addr_ok && idx == 3'd4) int_en_q <= PWDATA[2:0];
      rx_ovf_q  <= rx_ovf_d;
      irq_q     <= |(int_stat & int_en_q);
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
    end
  end

  // Storage needs no reset: cleared pointers make old contents unreachable.
  always_ff @(posedge PCLK) begin
    if (tx_push)           tx_mem[tx_wptr_q] <= PWDATA[7:0];
    if (rx_push && !flush) rx_mem[rx_wptr_q] <= spi_rx_data;
  end

  always_comb begin
    rdata = '0;
    if (rd_acc && addr_ok) begin
      case (idx)
        3'd0: rdata = {16'b0, clk_div_q, 5'b0, ctrl_cpha_q, ctrl_cpol_q, ctrl_en_q};
        3'd1: rdata = {12'b0, 4'(rx_cnt_q), 4'b0, 4'(tx_cnt_q), 2'b0,
                       rx_ovf_q, spi_busy, rx_empty, rx_full, tx_empty, tx_full};
        3'd3: rdata = rx_empty ? 32'b0 : {24'b0, rx_mem[rx_rptr_q]};
        3'd4: rdata = {29'b0, int_en_q};
        3'd5: rdata = {29'b0, int_stat};
        default: rdata = '0;
      endcase
    end
  end

  assign PRDATA  = APB_DATA_WIDTH'(rdata);
  assign PREADY  = 1'b1;
  assign PSLVERR = access & (~addr_ok
                             | (PWRITE  & (idx == 3'd2) & tx_full)
                             | (~PWRITE & (idx == 3'd3) & rx_empty));

  assign interrupt    = irq_q;
  assign spi_en       = ctrl_en_q;
  assign spi_cpol     = ctrl_cpol_q;
  assign spi_cpha     = ctrl_cpha_q;
  assign spi_clk_div  = clk_div_q;
  assign spi_tx_valid = ~tx_empty;
  assign spi_tx_data  = tx_mem[tx_rptr_q];

  assign unused_bits = ^{PADDR[1:0], PWDATA[APB_DATA_WIDTH-1:16]};

endmodule

// File: tb/tb_apb_spi_regif.sv
// Scoreboard bench for apb_spi_regif: APB transactions push their expected
// response into a queue, and a negedge monitor pops and compares whenever an
// access phase is on the bus. The reference model is queue based.
module tb_apb_spi_regif;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [11:0] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR, interrupt;
  logic        spi_en, spi_cpol, spi_cpha;
  logic [7:0]  spi_clk_div, spi_tx_data, spi_rx_data;
  logic        spi_tx_valid, spi_tx_ready, spi_rx_valid, spi_busy;

  always #5 PCLK = ~PCLK;

  apb_spi_regif dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .interrupt(interrupt),
    .spi_en(spi_en), .spi_cpol(spi_cpol), .spi_cpha(spi_cpha),
    .spi_clk_div(spi_clk_div), .spi_tx_data(spi_tx_data),
    .spi_tx_valid(spi_tx_valid), .spi_tx_ready(spi_tx_ready),
    .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
    .spi_busy(spi_busy)
  );

  int checks = 0;
  int errors = 0;
  int txn_id = 0;

  typedef struct {
    bit          is_read;
    logic [31:0] rdata;
    logic        err;
    int          id;
    logic [11:0] addr;
  } exp_t;
  exp_t exp_q[$];

  // Reference model
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  bit         m_en, m_cpol, m_cpha, m_ovf;
  logic [7:0] m_div;
  logic [2:0] m_int_en;

  task automatic m_reset();
    m_tx.delete(); m_rx.delete();
    m_en = 0; m_cpol = 0; m_cpha = 0; m_ovf = 0; m_div = 8'h00; m_int_en = 3'b000;
  endtask

  function automatic bit m_int();
    logic [2:0] st;
    st = {m_ovf, m_rx.size() != 0, m_tx.size() == 0};
    return |(st & m_int_en);
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'h0;
    s[0] = (m_tx.size() == 8);
    s[1] = (m_tx.size() == 0);
    s[2] = (m_rx.size() == 8);
    s[3] = (m_rx.size() == 0);
    s[4] = spi_busy;
    s[5] = m_ovf;
    s[11:8]  = 4'(m_tx.size());
    s[19:16] = 4'(m_rx.size());
    return s;
  endfunction

  function automatic bit m_mapped(input logic [11:0] a);
    return (a[11:5] == 7'd0) && (a[4:2] <= 3'd5);
  endfunction

  task automatic m_write(input logic [11:0] a, input logic [31:0] d, output logic err);
    err = 1'b0;
    if (!m_mapped(a)) err = 1'b1;
    else case (a[4:2])
      3'd0: begin
        m_en = d[0]; m_cpol = d[1]; m_cpha = d[2]; m_div = d[15:8];
        if (d[3]) begin m_tx.delete(); m_rx.delete(); end
      end
      3'd2: if (m_tx.size() == 8) err = 1'b1; else m_tx.push_back(d[7:0]);
      3'd4: m_int_en = d[2:0];
      3'd5: if (d[2]) m_ovf = 0;
      default: ;
    endcase
  endtask

  task automatic m_read(input logic [11:0] a, output logic [31:0] d, output logic err);
    err = 1'b0; d = 32'h0;
    if (!m_mapped(a)) err = 1'b1;
    else case (a[4:2])
      3'd0: d = {16'h0, m_div, 5'b0, m_cpha, m_cpol, m_en};
      3'd1: d = m_status();
      3'd3: if (m_rx.size() == 0) err = 1'b1; else d = {24'h0, m_rx.pop_front()};
      3'd4: d = {29'h0, m_int_en};
      3'd5: d = {29'h0, m_ovf, m_rx.size() != 0, m_tx.size() == 0};
      default: ;
    endcase
  endtask

  task automatic m_rx_push(input logic [7:0] b, input bit was_full);
    if (was_full) m_ovf = 1; else m_rx.push_back(b);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one compare per APB access phase.
  always @(negedge PCLK) begin
    exp_t e;
    if (PSEL && PENABLE) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL apb_unexpected: access at addr 0x%0h with no expected entry", PADDR);
      end else begin
        e = exp_q.pop_front();
        if (PSLVERR !== e.err || (e.is_read && PRDATA !== e.rdata)) begin
          errors++;
          $display("FAIL apb_txn%0d addr=0x%0h: PRDATA=0x%0h PSLVERR=%0b, expected PRDATA=0x%0h PSLVERR=%0b%s",
                   e.id, e.addr, PRDATA, PSLVERR, e.rdata, e.err, e.is_read ? "" : " (write)");
        end else begin
          $display("apb_txn%0d %s addr=0x%0h data=0x%0h err=%0b ok", e.id,
                   e.is_read ? "RD" : "WR", e.addr, PRDATA, PSLVERR);
        end
      end
    end
  end

  // One APB transfer. Optionally a byte arrives from the engine in the access cycle.
  task automatic apb(input bit wr, input logic [11:0] a, input logic [31:0] d,
                     input bit inj_rx, input logic [7:0] rxb);
    exp_t e;
    logic [31:0] rd;
    logic er;
    bit rx_was_full;
    PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    rx_was_full = (m_rx.size() == 8);
    if (wr) begin m_write(a, d, er); rd = 32'h0; end
    else m_read(a, rd, er);
    if (inj_rx) m_rx_push(rxb, rx_was_full);
    e.is_read = !wr; e.rdata = rd; e.err = er; e.id = txn_id++; e.addr = a;
    exp_q.push_back(e);
    PENABLE = 1;
    if (inj_rx) begin spi_rx_valid = 1; spi_rx_data = rxb; end
    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0; spi_rx_valid = 0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    apb(1'b1, a, d, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [11:0] a);
    apb(1'b0, a, 32'h0, 1'b0, 8'h00);
  endtask

  // Bus-idle cycle with engine-side activity; checks TX head and interrupt.
  task automatic idle(input bit rdy, input bit rxv, input logic [7:0] rxb);
    bit e_int;
    bit was_full;
    spi_tx_ready = rdy; spi_rx_valid = rxv; spi_rx_data = rxb;
    e_int = m_int();
    @(negedge PCLK);
    chk("tx_valid", {31'b0, spi_tx_valid}, {31'b0, m_tx.size() != 0});
    if (m_tx.size() != 0) chk("tx_head", {24'b0, spi_tx_data}, {24'b0, m_tx[0]});
    @(posedge PCLK); #1;
    was_full = (m_rx.size() == 8);
    if (rdy && m_tx.size() != 0) void'(m_tx.pop_front());
    if (rxv) m_rx_push(rxb, was_full);
    chk("interrupt", {31'b0, interrupt}, {31'b0, e_int});
    spi_tx_ready = 0; spi_rx_valid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time bound");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] a;
    logic [31:0] d;
    PRESETn = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    spi_tx_ready = 0; spi_rx_valid = 0; spi_rx_data = '0; spi_busy = 0;
    m_reset();
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1;

    // Reset state
    chk("reset_interrupt", {31'b0, interrupt}, 32'h0);
    chk("reset_tx_valid", {31'b0, spi_tx_valid}, 32'h0);
    chk("reset_status_model", m_status(), 32'h0000_000A);
    rd(12'h004);

    // CTRL write/readback
    wr(12'h000, 32'h0000_0A07);
    chk("spi_ctrl_bits", {29'b0, spi_cpha, spi_cpol, spi_en}, 32'h7);
    chk("spi_clk_div", {24'b0, spi_clk_div}, 32'h0A);
    rd(12'h000);

    // Fill TX, overflow attempt, then drain
    for (int i = 1; i <= 8; i++) wr(12'h008, 32'(i * 8'h11));
    rd(12'h004);
    wr(12'h008, 32'h99);
    chk("tx_head_first", {24'b0, spi_tx_data}, 32'h11);
    for (int i = 0; i < 8; i++) idle(1'b1, 1'b0, 8'h00);
    rd(12'h004);

    // RX overflow with INT_EN=rx_ovf
    wr(12'h010, 32'h4);
    for (int i = 0; i < 9; i++) idle(1'b0, 1'b1, 8'(8'hA0 + i));
    chk("int_after_ovf", {31'b0, interrupt}, 32'h0);
    idle(1'b0, 1'b0, 8'h00);
    chk("int_ovf_next", {31'b0, interrupt}, 32'h1);
    rd(12'h004);
    for (int i = 0; i < 9; i++) rd(12'h00C);

    // W1C clears ovf, interrupt drops one cycle later
    wr(12'h014, 32'h4);
    chk("int_w1c_same", {31'b0, interrupt}, 32'h1);
    idle(1'b0, 1'b0, 8'h00);
    chk("int_w1c_after", {31'b0, interrupt}, 32'h0);

    // Same-cycle W1C and overflow: set wins
    for (int i = 0; i < 8; i++) idle(1'b0, 1'b1, 8'(8'hB0 + i));
    apb(1'b1, 12'h014, 32'h4, 1'b1, 8'hEE);
    rd(12'h004);
    rd(12'h014);

    // Unmapped accesses
    rd(12'h018);
    rd(12'h81C);
    wr(12'h01C, 32'hFFFF_FFFF);

    // Flush with both FIFOs half full
    for (int i = 0; i < 4; i++) rd(12'h00C);
    for (int i = 0; i < 4; i++) wr(12'h008, 32'(8'hC0 + i));
    rd(12'h004);
    wr(12'h000, 32'h0000_0A0F);
    rd(12'h004);
    rd(12'h000);
    wr(12'h014, 32'h4);

    // Simultaneous TX push and pop (non-full, non-empty)
    wr(12'h008, 32'h5A);
    wr(12'h008, 32'h5B);
    begin
      exp_t e;
      PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 12'h008; PWDATA = 32'h5C;
      @(posedge PCLK); #1;
      e.is_read = 0; e.rdata = 0; e.err = 0; e.id = txn_id++; e.addr = 12'h008;
      exp_q.push_back(e);
      m_tx.push_back(8'h5C);
      void'(m_tx.pop_front());
      PENABLE = 1; spi_tx_ready = 1;
      @(posedge PCLK); #1;
      PSEL = 0; PENABLE = 0; spi_tx_ready = 0;
    end
    rd(12'h004);
    idle(1'b0, 1'b0, 8'h00);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 6) begin
        a = 12'($urandom_range(0, 7) << 2) | 12'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) a[8] = 1'b1;
        d = $urandom;
        if (a[4:2] == 3'd0 && $urandom_range(0, 5) != 0) d[3] = 1'b0;
        apb($urandom_range(0, 1) == 1, a, d, 1'b0, 8'h00);
      end else begin
        spi_busy = ($urandom_range(0, 1) == 1);
        idle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom));
      end
    end
    spi_busy = 0;
    rd(12'h004);

    // Reset mid-stream
    wr(12'h000, 32'h0000_3305);
    for (int i = 0; i < 3; i++) wr(12'h008, 32'(8'hD0 + i));
    idle(1'b0, 1'b1, 8'h71);
    idle(1'b0, 1'b1, 8'h72);
    PRESETn = 0;
    @(posedge PCLK); #1;
    PRESETn = 1;
    m_reset();
    chk("rst_spi_en", {31'b0, spi_en}, 32'h0);
    chk("rst_clk_div", {24'b0, spi_clk_div}, 32'h0);
    chk("rst_tx_valid", {31'b0, spi_tx_valid}, 32'h0);
    chk("rst_interrupt", {31'b0, interrupt}, 32'h0);
    rd(12'h004);
    rd(12'h000);
    rd(12'h00C);

    @(negedge PCLK);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
